// File: rtl/mem_uart_pkg.sv
// mem_uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register offsets (addr[3:2]), STATUS bit positions and the
//   transmit FSM state type.
//   Optional feature macro: MEM_UART_TX_PARITY_EN (see mem_uart_tx.sv).
package mem_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_LVL_LSB = 4;   // level occupies bits [7:4]
    localparam int ST_PARITY  = 8;   // reads 1 when the parity build is selected

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Small synchronous FIFO holding bytes waiting to be serialized.
//   Pointers carry one extra wrap bit so full/empty are distinguished
//   and level = wptr - rptr.
// Ports:
//   clk, reset          clock, synchronous active-high reset (pointers only)
//   i_push, i_din       push request and data (ignored when full unless popping)
//   i_pop               pop request (ignored when empty)
//   o_dout              head entry, valid while !o_empty
//   o_full, o_empty     occupancy flags
//   o_level             number of stored entries
module uart_tx_fifo
    import mem_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_level   = r_wptr - r_rptr;
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign o_dout    = r_mem[r_rptr[AW-1:0]];
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mem_uart_tx.sv
// mem_uart_tx
//   UART transmitter responding on the picorv32 native memory bus.
//   Bytes written to TXDATA are queued and sent 8N1, LSB first.
//   Registers (offset = addr[3:2]): 0 TXDATA (wo), 1 STATUS (ro,
//   write bit3=1 clears OVF), 2 DIV (rw, bits[15:0]), 3 reserved.
//   Optional macro MEM_UART_TX_PARITY_EN inserts an even-parity bit
//   between the data bits and the stop bit and sets STATUS bit8.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   mem_valid    request valid
//   mem_addr     byte address
//   mem_wdata    write data
//   mem_wstrb    byte strobes, 0 = read
//   mem_sel      mem_valid && address in this block's 16-byte window
//   mem_ready    single-cycle acknowledge
//   mem_rdata    read data, valid while mem_ready
//   uart_tx      serial output, idle high
module mem_uart_tx
    import mem_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        w_sel, w_acc, w_wr_tx, w_push, w_pop, w_tick, w_tx;
    logic [1:0]  w_off;
    logic [31:0] w_status, w_rd_data;
    logic [7:0]  w_fifo_dout;
    logic        w_full, w_empty;
    logic [AW:0] w_level;
    logic        w_unused;

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_ovf;
    logic [15:0] r_div;
    uart_state_e r_state, w_state_nxt;
    logic [15:0] r_timer;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_par;

    assign w_unused  = &{1'b0, mem_addr[1:0], mem_wdata[31:16]};
    assign w_sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = mem_addr[3:2];
    // Register side effects occur only in the acknowledge cycle
    assign w_acc     = r_ready && w_sel;
    assign w_wr_tx   = w_acc && (w_off == REG_TXDATA) && mem_wstrb[0];
    assign w_push    = w_wr_tx && (!w_full || w_pop);
    assign mem_sel   = w_sel;
    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign uart_tx   = w_tx;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_status                     = '0;
        w_status[ST_FULL]            = w_full;
        w_status[ST_EMPTY]           = w_empty;
        w_status[ST_BUSY]            = (r_state != IDLE);
        w_status[ST_OVF]             = r_ovf;
        w_status[ST_LVL_LSB +: 4]    = 4'(w_level);
`ifdef MEM_UART_TX_PARITY_EN
        w_status[ST_PARITY]          = 1'b1;
`else
        w_status[ST_PARITY]          = 1'b0;
`endif
    end

    always_comb begin
        case (w_off)
            REG_STATUS: w_rd_data = w_status;
            REG_DIV:    w_rd_data = {16'h0000, r_div};
            default:    w_rd_data = '0;
        endcase
    end

    // Bus handshake and register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DEFAULT_DIV;
        end else begin
            r_ready <= w_sel && !r_ready;
            r_rdata <= (w_sel && !r_ready && (mem_wstrb == 4'b0000)) ? w_rd_data : '0;
            if (w_wr_tx && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_acc && (w_off == REG_STATUS) && (|mem_wstrb) && mem_wdata[ST_OVF])
                r_ovf <= 1'b0;
            if (w_acc && (w_off == REG_DIV)) begin
                if (mem_wstrb[0]) r_div[7:0]  <= mem_wdata[7:0];
                if (mem_wstrb[1]) r_div[15:8] <= mem_wdata[15:8];
            end
        end
    end

    // Transmit FSM: next state, FIFO pop and line level
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        w_tick      = (r_timer == 16'd0);
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_tick && (r_bitcnt == 3'd7)) begin
`ifdef MEM_UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
                w_tx = r_par;
                if (w_tick) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_tick) begin
                    // Chain straight into the next frame when data is waiting
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // DIV is sampled on every reload, so a new value applies at the next bit
            if (w_pop) begin
                r_timer  <= r_div;
                r_bitcnt <= '0;
            end else if (r_state != IDLE) begin
                if (w_tick) begin
                    r_timer <= r_div;
                    if (r_state == DATA) r_bitcnt <= r_bitcnt + 3'd1;
                end else begin
                    r_timer <= r_timer - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_par   <= ^w_fifo_dout;
        end else if ((r_state == DATA) && w_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule
